// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, default width and negate helper for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  // Widest operand the negate helper handles; callers truncate the result.
  localparam int NEG_W = 64;

  // Two's-complement negate; the low bits are correct for any narrower operand.
  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
    return (~v) + NEG_W'(1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared with the adder datapath
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_step.sv
// rtl/sub_step.sv - WIDTH+1 bit ripple subtractor (a + ~b + 1) for one restoring step
module sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow_n
);

  // carry[0] is the +1 of the two's-complement subtract
  logic [WIDTH+1:0] carry;

  assign carry[0] = 1'b1;

  genvar i;
  for (i = 0; i <= WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  // Final carry high means a >= b, i.e. no borrow
  assign borrow_n = carry[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring signed/unsigned divider with start/done handshake
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH:0]    p;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  dmag;
  logic              sign_q;
  logic              sign_r;

  logic              dvd_neg;
  logic              dvs_neg;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH:0]    trial;
  logic [WIDTH:0]    diff;
  logic              borrow_n;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return WIDTH'(twos_neg(NEG_W'(v)));
  endfunction

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? neg_w(dividend) : dividend;
  assign dvs_mag = dvs_neg ? neg_w(divisor) : divisor;

  // Shifted partial remainder: P's top bit is always clear here because P < |divisor|
  assign trial = {p[WIDTH-1:0], q[WIDTH-1]};

  sub_step #(.WIDTH(WIDTH)) u_sub (
    .a       (trial),
    .b       ({1'b0, dmag}),
    .diff    (diff),
    .borrow_n(borrow_n)
  );

  assign busy = (state == CALC) || (state == FIXUP);
  assign done = (state == DONE);

  // Control FSM, iteration datapath and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      dmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              cnt    <= CNT_W'(WIDTH - 1);
              p      <= '0;
              q      <= dvd_mag;
              dmag   <= dvs_mag;
              sign_q <= dvd_neg ^ dvs_neg;
              sign_r <= dvd_neg;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (borrow_n) begin
            p <= diff;
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            p <= trial;
            q <= {q[WIDTH-2:0], 1'b0};
          end
          if (cnt == '0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIXUP: begin
          quotient    <= sign_q ? neg_w(q) : q;
          remainder   <= sign_r ? neg_w(WIDTH'(p)) : WIDTH'(p);
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks;
  int errors;

  seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat = cycles from the accepting edge to the done sample.
  // An extra start (xa/xb) is pulsed at iteration xn when xn > 0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int xn, input logic [31:0] xa, input logic [31:0] xb,
                        output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    @(posedge clk); #1;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
      if (n == xn) begin
        dividend  = xa;
        divisor   = xb;
        signed_op = 1'b0;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL uns_latency got %0d want 34", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL uns_busy_cycles got %0d want 33", bc); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL uns_quotient got %h want %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL uns_remainder got %h want %h", remainder, 32'd2); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL uns_dbz got %0b want 0", div_by_zero); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (quotient !== 32'd14 || done !== 1'b0) begin errors++; $display("FAIL uns_hold got q=%h done=%0b want q=%h done=0", quotient, done, 32'd14); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'hFFFF_FFF2) begin errors++; $display("FAIL sgn_neg_dvd_q got %h want fffffff2", quotient); end
    checks++; if (remainder !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sgn_neg_dvd_r got %h want fffffffe", remainder); end
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'hFFFF_FFF2) begin errors++; $display("FAIL sgn_neg_dvs_q got %h want fffffff2", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL sgn_neg_dvs_r got %h want 00000002", remainder); end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    run_op(32'h1234_5678, 32'd0, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy got %0d want 0", bc); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quotient got %h want ffffffff", quotient); end
    checks++; if (remainder !== 32'h1234_5678) begin errors++; $display("FAIL dbz_remainder got %h want 12345678", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %0b want 1", div_by_zero); end
    run_op(32'd9, 32'd3, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL dbz_next_q got %h want 3", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL dbz_next_r got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %0b want 0", div_by_zero); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got %h want 80000000", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL ovf_r got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %0b want 0", div_by_zero); end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_q got %h want ffffffff", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL umax_r got %h want 0", remainder); end
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, 4, 32'd50, 32'd5, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL ign_latency got %0d want 34", lat); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL ign_q got %h want e", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL ign_r got %h want 2", remainder); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(32'd45, 32'd4, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency got %0d want 34", lat); end
    // run_op's first edge ends the done cycle, so the next start lands in the cycle after done
    run_op(32'd77, 32'd10, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
    checks++; if (quotient !== 32'd7) begin errors++; $display("FAIL b2b_q got %h want 7", quotient); end
    checks++; if (remainder !== 32'd7) begin errors++; $display("FAIL b2b_r got %h want 7", remainder); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int seen;
    @(posedge clk); #1;
    dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %0b want 0", done); end
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL rmid_q got %h want 0", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL rmid_r got %h want 0", remainder); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles want 0", seen); end
    run_op(32'd20, 32'd6, 1'b0, 0, 0, 0, lat, bc);
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL rmid_next_q got %h want 3", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL rmid_next_r got %h want 2", remainder); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
